// File: rtl/bf16_cvt_scheduler_pkg.sv
// Shared definitions for the BF16 conversion scheduler: op encodings,
// scheduler state type, fpcsr flag bit positions and the latched request.
package cvt_pkg;

  // Op encodings on req_op
  localparam logic CVT_B2F = 1'b0;  // BF16 -> FP32
  localparam logic CVT_F2B = 1'b1;  // FP32 -> BF16

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    WAIT = 2'd2,
    RESP = 2'd3
  } cvt_state_e;

  // fpcsr flag bit positions within the 4-bit {NV,OF,UF,NX} field
  localparam int unsigned FLAG_NV = 3;
  localparam int unsigned FLAG_OF = 2;
  localparam int unsigned FLAG_UF = 1;
  localparam int unsigned FLAG_NX = 0;

  // Widest tag the request record can carry; narrower tags sit in the LSBs.
  localparam int unsigned CVT_TAG_W_MAX = 16;

  typedef struct packed {
    logic                     op;
    logic [31:0]              data;
    logic [CVT_TAG_W_MAX-1:0] tag;
  } cvt_req_t;

endpackage

// File: rtl/bf16_cvt_scheduler_arb.sv
// Two-input round-robin arbiter for the conversion scheduler.
//   req_valid  : per-port request valid
//   rr_ptr     : preferred port this cycle
//   accept     : the grant is being taken this cycle
//   gnt        : one-hot grant (zero when nothing is valid)
//   gnt_id     : index of the granted port
//   rr_ptr_nxt : pointer for next cycle (moves past the winner on accept)
module cvt_rr_arb2 (
  input  logic [1:0] req_valid,
  input  logic       rr_ptr,
  input  logic       accept,
  output logic [1:0] gnt,
  output logic       gnt_id,
  output logic       rr_ptr_nxt
);

  always_comb begin
    gnt    = '0;
    gnt_id = rr_ptr;
    if (!req_valid[rr_ptr] && req_valid[~rr_ptr]) begin
      gnt_id = ~rr_ptr;
    end
    if (req_valid != 2'b00) begin
      gnt[gnt_id] = 1'b1;
    end
    rr_ptr_nxt = accept ? ~gnt_id : rr_ptr;
  end

endmodule

// File: rtl/bf16_cvt_scheduler.sv
// Shares one BF16->FP32 and one FP32->BF16 converter between two requesters
// (port 0 scalar issue, port 1 vector lane). One op in flight at a time:
// accept -> EXEC (enable pulse) -> WAIT (CVT_LAT cycles) -> RESP.
// Ports:
//   clk, reset                      clock, async active-high reset
//   req_valid/ready/op/data/tag     per-port request channel (port 0 in LSBs)
//   cvt_en_b2f, cvt_en_f2b          one-cycle converter enables
//   cvt_operand                     operand bus to both converters
//   cvt_res_*, cvt_flags_*          converter results and fpcsr flags
//   rsp_valid/ready/id/tag/data/flags  response channel
//   flags_clr, sticky_flags         sticky fpcsr accumulation for the CSR file
module bf16_cvt_scheduler
  import cvt_pkg::*;
#(
  parameter int unsigned TAG_W   = 4,
  parameter int unsigned CVT_LAT = 1
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [1:0]         req_valid,
  output logic [1:0]         req_ready,
  input  logic [1:0]         req_op,
  input  logic [63:0]        req_data,
  input  logic [2*TAG_W-1:0] req_tag,
  output logic               cvt_en_b2f,
  output logic               cvt_en_f2b,
  output logic [31:0]        cvt_operand,
  input  logic [31:0]        cvt_res_b2f,
  input  logic [3:0]         cvt_flags_b2f,
  input  logic [15:0]        cvt_res_f2b,
  input  logic [3:0]         cvt_flags_f2b,
  output logic               rsp_valid,
  input  logic               rsp_ready,
  output logic               rsp_id,
  output logic [TAG_W-1:0]   rsp_tag,
  output logic [31:0]        rsp_data,
  output logic [3:0]         rsp_flags,
  input  logic               flags_clr,
  output logic [3:0]         sticky_flags
);

  localparam int unsigned CNT_W = (CVT_LAT > 1) ? $clog2(CVT_LAT) : 1;

  cvt_state_e       state;
  logic             rr_ptr;
  logic             rr_ptr_nxt;
  logic [1:0]       gnt;
  logic             gnt_id;
  logic             accept;
  logic [CNT_W-1:0] lat_cnt;
  cvt_req_t         sel_req;
  cvt_req_t         lat_req;
  logic [3:0]       cap_flags;
  logic [31:0]      cap_data;
  logic             unused_tag_hi;

  // Gated by reset so requesters never see an accept while reset is held.
  assign accept    = (state == IDLE) && (req_valid != 2'b00) && !reset;
  assign req_ready = accept ? gnt : '0;

  cvt_rr_arb2 u_arb (
    .req_valid  (req_valid),
    .rr_ptr     (rr_ptr),
    .accept     (accept),
    .gnt        (gnt),
    .gnt_id     (gnt_id),
    .rr_ptr_nxt (rr_ptr_nxt)
  );

  always_comb begin
    sel_req      = '0;
    sel_req.op   = req_op[gnt_id];
    sel_req.data = gnt_id ? req_data[63:32] : req_data[31:0];
    sel_req.tag[TAG_W-1:0] = gnt_id ? req_tag[2*TAG_W-1:TAG_W] : req_tag[TAG_W-1:0];
  end

  always_comb begin
    if (lat_req.op == CVT_F2B) begin
      cap_data  = {16'h0000, cvt_res_f2b};
      cap_flags = cvt_flags_f2b;
    end else begin
      cap_data  = cvt_res_b2f;
      cap_flags = cvt_flags_b2f;
    end
  end

  assign cvt_operand = lat_req.data;
  assign cvt_en_b2f  = (state == EXEC) && (lat_req.op == CVT_B2F);
  assign cvt_en_f2b  = (state == EXEC) && (lat_req.op == CVT_F2B);
  assign rsp_valid   = (state == RESP);
  assign rsp_tag     = lat_req.tag[TAG_W-1:0];

  // Tag bits above TAG_W are always zero; folded here so they are not left dangling.
  assign unused_tag_hi = ^lat_req.tag;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state        <= IDLE;
      rr_ptr       <= 1'b0;
      lat_req      <= '0;
      lat_cnt      <= '0;
      rsp_id       <= 1'b0;
      rsp_data     <= '0;
      rsp_flags    <= '0;
      sticky_flags <= '0;
    end else begin
      rr_ptr <= rr_ptr_nxt;
      if (flags_clr) begin
        sticky_flags <= '0;
      end
      case (state)
        IDLE: begin
          if (accept) begin
            lat_req <= sel_req;
            rsp_id  <= gnt_id;
            state   <= EXEC;
          end
        end
        EXEC: begin
          lat_cnt <= CNT_W'(CVT_LAT - 1);
          state   <= WAIT;
        end
        WAIT: begin
          if (lat_cnt != '0) begin
            lat_cnt <= lat_cnt - CNT_W'(1);
          end else begin
            rsp_data  <= cap_data;
            rsp_flags <= cap_flags;
            // Captured flags survive a same-cycle clear.
            sticky_flags <= (flags_clr ? 4'h0 : sticky_flags) | cap_flags;
            state     <= RESP;
          end
        end
        RESP: begin
          if (rsp_ready) begin
            state <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_bf16_cvt_scheduler.sv
module tb_bf16_cvt_scheduler;

  logic        clk = 1'b0;
  logic        reset, reset3;
  logic [1:0]  req_valid, req_valid3, req_ready, req_ready3;
  logic [1:0]  req_op;
  logic [63:0] req_data;
  logic [7:0]  req_tag;
  logic        rsp_ready, flags_clr;

  logic        cvt_en_b2f, cvt_en_f2b, rsp_valid, rsp_id;
  logic [31:0] cvt_operand, cvt_res_b2f, rsp_data;
  logic [15:0] cvt_res_f2b;
  logic [3:0]  cvt_flags_b2f, cvt_flags_f2b, rsp_tag, rsp_flags, sticky_flags;

  logic        cvt_en_b2f3, cvt_en_f2b3, rsp_valid3, rsp_id3;
  logic [31:0] cvt_operand3, cvt_res_b2f3, rsp_data3;
  logic [15:0] cvt_res_f2b3;
  logic [3:0]  cvt_flags_b2f3, cvt_flags_f2b3, rsp_tag3, rsp_flags3, sticky3;

  int checks = 0;
  int fails  = 0;

  always #5 clk = ~clk;

  bf16_cvt_scheduler #(.TAG_W(4), .CVT_LAT(1)) dut (
    .clk(clk), .reset(reset), .req_valid(req_valid), .req_ready(req_ready),
    .req_op(req_op), .req_data(req_data), .req_tag(req_tag),
    .cvt_en_b2f(cvt_en_b2f), .cvt_en_f2b(cvt_en_f2b), .cvt_operand(cvt_operand),
    .cvt_res_b2f(cvt_res_b2f), .cvt_flags_b2f(cvt_flags_b2f),
    .cvt_res_f2b(cvt_res_f2b), .cvt_flags_f2b(cvt_flags_f2b),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_id(rsp_id), .rsp_tag(rsp_tag),
    .rsp_data(rsp_data), .rsp_flags(rsp_flags), .flags_clr(flags_clr),
    .sticky_flags(sticky_flags)
  );

  bf16_cvt_scheduler #(.TAG_W(4), .CVT_LAT(3)) dut3 (
    .clk(clk), .reset(reset3), .req_valid(req_valid3), .req_ready(req_ready3),
    .req_op(req_op), .req_data(req_data), .req_tag(req_tag),
    .cvt_en_b2f(cvt_en_b2f3), .cvt_en_f2b(cvt_en_f2b3), .cvt_operand(cvt_operand3),
    .cvt_res_b2f(cvt_res_b2f3), .cvt_flags_b2f(cvt_flags_b2f3),
    .cvt_res_f2b(cvt_res_f2b3), .cvt_flags_f2b(cvt_flags_f2b3),
    .rsp_valid(rsp_valid3), .rsp_ready(rsp_ready), .rsp_id(rsp_id3), .rsp_tag(rsp_tag3),
    .rsp_data(rsp_data3), .rsp_flags(rsp_flags3), .flags_clr(flags_clr),
    .sticky_flags(sticky3)
  );

  // Converter behaviour: NaN -> canonical quiet NaN with NV; f2b rounds to nearest even.
  function automatic logic [35:0] ref_b2f(input logic [15:0] h);
    if (h[14:7] == 8'hFF && h[6:0] != 7'd0) return {4'b1000, 32'h7FC0_0000};
    return {4'b0000, h, 16'h0000};
  endfunction

  function automatic logic [19:0] ref_f2b(input logic [31:0] x);
    logic [16:0] r;
    logic [3:0]  f;
    if (x[30:23] == 8'hFF && x[22:0] != 23'd0) return {4'b1000, 16'h7FC0};
    if (x[30:23] == 8'hFF) return {4'b0000, x[31:16]};
    f = (x[15:0] != 16'd0) ? 4'b0001 : 4'b0000;
    r = {1'b0, x[31:16]} + ((x[15] && (x[14:0] != 15'd0 || x[16])) ? 17'd1 : 17'd0);
    if (r[14:7] == 8'hFF) f = f | 4'b0100;
    return {f, r[15:0]};
  endfunction

  // Converter stand-ins: result becomes stable CVT_LAT edges after the enable
  // edge; before that the buses carry garbage.
  logic [31:0] m1_op, m3_op;
  int unsigned m1_age, m3_age;

  always @(posedge clk or posedge reset)
    if (reset) begin m1_age <= 0; m1_op <= '0; end
    else if (cvt_en_b2f | cvt_en_f2b) begin m1_op <= cvt_operand; m1_age <= 1; end
    else if (m1_age != 0 && m1_age < 1000) m1_age <= m1_age + 1;

  always @(posedge clk or posedge reset3)
    if (reset3) begin m3_age <= 0; m3_op <= '0; end
    else if (cvt_en_b2f3 | cvt_en_f2b3) begin m3_op <= cvt_operand3; m3_age <= 1; end
    else if (m3_age != 0 && m3_age < 1000) m3_age <= m3_age + 1;

  assign {cvt_flags_b2f, cvt_res_b2f}   = (m1_age >= 1) ? ref_b2f(m1_op[15:0]) : {4'hF, 32'hDEAD_BEEF};
  assign {cvt_flags_f2b, cvt_res_f2b}   = (m1_age >= 1) ? ref_f2b(m1_op) : {4'hF, 16'hDEAD};
  assign {cvt_flags_b2f3, cvt_res_b2f3} = (m3_age >= 3) ? ref_b2f(m3_op[15:0]) : {4'hF, 32'hDEAD_BEEF};
  assign {cvt_flags_f2b3, cvt_res_f2b3} = (m3_age >= 3) ? ref_f2b(m3_op) : {4'hF, 16'hDEAD};

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    req_valid = '0; req_valid3 = '0; rsp_ready = 1'b0; flags_clr = 1'b0;
  endtask

  task automatic do_reset();
    idle_inputs();
    reset = 1'b1;
    step(); step();
    reset = 1'b0;
    step();
  endtask

  task automatic set_port(input int p, input logic op, input logic [31:0] d, input logic [3:0] t);
    req_op[p] = op;
    if (p == 0) begin req_data[31:0] = d; req_tag[3:0] = t; end
    else begin req_data[63:32] = d; req_tag[7:4] = t; end
  endtask

  // Presents a request on port p and returns in the EXEC cycle after acceptance.
  task automatic accept_one(input int p, input logic op, input logic [31:0] d,
                            input logic [3:0] t, output bit ok);
    ok = 1'b0;
    set_port(p, op, d, t);
    req_valid = 2'b01 << p;
    for (int i = 0; i < 20 && !ok; i++) begin
      #1;
      ok = req_ready[p];
      step();
    end
    req_valid = '0;
  endtask

  task automatic wait_rsp(input int max, output bit ok);
    ok = rsp_valid;
    for (int i = 0; i < max && !ok; i++) begin
      step();
      ok = rsp_valid;
    end
  endtask

  task automatic test_reset();
    reset = 1'b1; reset3 = 1'b1;
    rsp_ready = 1'b0; flags_clr = 1'b0;
    req_op = '0; req_data = '0; req_tag = '0;
    req_valid = 2'b11; req_valid3 = 2'b11;
    #1;
    checks++;
    if ({req_ready, req_ready3} !== 4'b0000) begin
      fails++;
      $display("FAIL reset_req_ready: got %b expected 0000", {req_ready, req_ready3});
    end
    checks++;
    if ({rsp_valid, rsp_id, rsp_tag, rsp_data, rsp_flags, sticky_flags, cvt_en_b2f, cvt_en_f2b, cvt_operand} !== 80'h0) begin
      fails++;
      $display("FAIL reset_outputs: got %h expected 0",
               {rsp_valid, rsp_id, rsp_tag, rsp_data, rsp_flags, sticky_flags, cvt_en_b2f, cvt_en_f2b, cvt_operand});
    end
    step(); step();
    idle_inputs();
    reset = 1'b0; reset3 = 1'b0;
    step();
    checks++;
    if ({rsp_valid, rsp_valid3, sticky_flags, sticky3, cvt_en_b2f, cvt_en_f2b} !== 12'h0) begin
      fails++;
      $display("FAIL reset_release: got %h expected 0",
               {rsp_valid, rsp_valid3, sticky_flags, sticky3, cvt_en_b2f, cvt_en_f2b});
    end
  endtask

  task automatic test_basic();
    bit ok;
    accept_one(0, 1'b0, 32'h0000_3F80, 4'd5, ok);
    checks++;
    if (!ok) begin fails++; $display("FAIL basic_accept: got no grant expected grant on port 0"); end
    checks++;
    if ({cvt_en_b2f, cvt_en_f2b, rsp_valid} !== 3'b100) begin
      fails++;
      $display("FAIL basic_exec_en: got %b expected 100", {cvt_en_b2f, cvt_en_f2b, rsp_valid});
    end
    checks++;
    if (cvt_operand !== 32'h0000_3F80) begin
      fails++;
      $display("FAIL basic_operand: got %h expected 00003f80", cvt_operand);
    end
    step();
    checks++;
    if ({cvt_en_b2f, cvt_en_f2b, rsp_valid} !== 3'b000) begin
      fails++;
      $display("FAIL basic_wait: got %b expected 000", {cvt_en_b2f, cvt_en_f2b, rsp_valid});
    end
    step();
    checks++;
    if (rsp_valid !== 1'b1) begin
      fails++;
      $display("FAIL basic_rsp_latency: got rsp_valid=%b expected 1", rsp_valid);
    end
    checks++;
    if ({rsp_id, rsp_tag, rsp_data, rsp_flags, sticky_flags} !== {1'b0, 4'd5, 32'h3F80_0000, 4'h0, 4'h0}) begin
      fails++;
      $display("FAIL basic_rsp: got id=%b tag=%h data=%h flags=%b sticky=%b expected 0 5 3f800000 0000 0000",
               rsp_id, rsp_tag, rsp_data, rsp_flags, sticky_flags);
    end
    rsp_ready = 1'b1;
    step();
    rsp_ready = 1'b0;
    checks++;
    if (rsp_valid !== 1'b0) begin
      fails++;
      $display("FAIL basic_rsp_drop: got %b expected 0", rsp_valid);
    end
  endtask

  task automatic test_nan();
    bit ok;
    logic [3:0] t;
    t = 4'($urandom);
    accept_one(1, 1'b0, 32'h0000_7FC1, t, ok);
    checks++;
    if (!ok) begin fails++; $display("FAIL nan_accept: got no grant expected grant on port 1"); end
    wait_rsp(6, ok);
    checks++;
    if (!ok || {rsp_id, rsp_tag, rsp_data, rsp_flags, sticky_flags} !== {1'b1, t, 32'h7FC0_0000, 4'b1000, 4'b1000}) begin
      fails++;
      $display("FAIL nan_rsp: got valid=%b id=%b tag=%h data=%h flags=%b sticky=%b expected 1 1 %h 7fc00000 1000 1000",
               ok, rsp_id, rsp_tag, rsp_data, rsp_flags, sticky_flags, t);
    end
    rsp_ready = 1'b1; step(); rsp_ready = 1'b0;
  endtask

  task automatic test_rr();
    logic [31:0] d [2];
    logic [3:0]  t [2];
    logic [1:0]  o;
    logic [35:0] e;
    logic [19:0] e2;
    logic [41:0] exp_rsp;
    int order [$];
    bit busy, hs, rhs, ok;
    int g;
    busy = 0; g = 0; exp_rsp = '0;
    do_reset();
    for (int p = 0; p < 2; p++) begin
      d[p] = $urandom & 32'h3FFF_3FFF; t[p] = 4'($urandom); o[p] = 1'($urandom_range(0, 1));
      set_port(p, o[p], d[p], t[p]);
    end
    req_valid = 2'b11; rsp_ready = 1'b1;
    for (int c = 0; c < 80 && order.size() < 4; c++) begin
      #1;
      checks++;
      if (req_ready === 2'b11 || (busy && req_ready !== 2'b00)) begin
        fails++;
        $display("FAIL rr_ready_excl: got %b expected one-hot in idle, 00 when busy", req_ready);
      end
      hs = (req_ready != 2'b00);
      g = req_ready[1] ? 1 : 0;
      rhs = rsp_valid;
      if (rsp_valid) begin
        checks++;
        if ({rsp_id, rsp_tag, rsp_data, rsp_flags} !== exp_rsp) begin
          fails++;
          $display("FAIL rr_rsp: got %h expected %h", {rsp_id, rsp_tag, rsp_data, rsp_flags}, exp_rsp);
        end
      end
      if (hs) begin
        order.push_back(g);
        e = ref_b2f(d[g][15:0]); e2 = ref_f2b(d[g]);
        exp_rsp = o[g] ? {g[0], t[g], 16'h0, e2[15:0], e2[19:16]} : {g[0], t[g], e[31:0], e[35:32]};
      end
      step();
      if (rhs) busy = 0;
      if (hs) begin
        busy = 1;
        d[g] = $urandom & 32'h3FFF_3FFF; t[g] = 4'($urandom); o[g] = 1'($urandom_range(0, 1));
        set_port(g, o[g], d[g], t[g]);
      end
    end
    wait_rsp(10, ok);
    checks++;
    if (!ok || {rsp_id, rsp_tag, rsp_data, rsp_flags} !== exp_rsp) begin
      fails++;
      $display("FAIL rr_last_rsp: got valid=%b %h expected %h", ok, {rsp_id, rsp_tag, rsp_data, rsp_flags}, exp_rsp);
    end
    step();
    idle_inputs();
    checks++;
    if (order.size() != 4) begin
      fails++;
      $display("FAIL rr_count: got %0d expected 4", order.size());
    end
    for (int i = 0; i < order.size(); i++) begin
      checks++;
      if (order[i] != (i % 2)) begin
        fails++;
        $display("FAIL rr_order[%0d]: got %0d expected %0d", i, order[i], i % 2);
      end
    end
  endtask

  task automatic test_backpressure();
    bit ok;
    accept_one(0, 1'b1, 32'h4049_0FDB, 4'd3, ok);
    wait_rsp(6, ok);
    checks++;
    if (!ok) begin fails++; $display("FAIL bp_rsp: got no rsp_valid expected rsp_valid"); end
    set_port(0, 1'b0, 32'h0000_1234, 4'd1);
    set_port(1, 1'b0, 32'h0000_5678, 4'd2);
    req_valid = 2'b11;
    for (int i = 0; i < 6; i++) begin
      #1;
      checks++;
      if ({rsp_valid, rsp_id, rsp_tag, rsp_data, rsp_flags} !== {1'b1, 1'b0, 4'd3, 32'h0000_4049, 4'b0001}) begin
        fails++;
        $display("FAIL bp_stable[%0d]: got %h expected 10334049 1", i, {rsp_valid, rsp_id, rsp_tag, rsp_data, rsp_flags});
      end
      checks++;
      if ({req_ready, cvt_en_b2f, cvt_en_f2b} !== 4'b0000) begin
        fails++;
        $display("FAIL bp_quiet[%0d]: got %b expected 0000", i, {req_ready, cvt_en_b2f, cvt_en_f2b});
      end
      step();
    end
    rsp_ready = 1'b1;
    step();
    idle_inputs();
    #1;
    checks++;
    if ({rsp_valid, req_ready} !== 3'b000) begin
      fails++;
      $display("FAIL bp_complete: got %b expected 000", {rsp_valid, req_ready});
    end
    step();
  endtask

  task automatic test_flags();
    bit ok;
    flags_clr = 1'b1; step(); flags_clr = 1'b0;
    checks++;
    if (sticky_flags !== 4'h0) begin
      fails++;
      $display("FAIL flags_clr_pre: got %b expected 0000", sticky_flags);
    end
    accept_one(1, 1'b0, 32'h0000_FF81, 4'd9, ok);
    wait_rsp(6, ok);
    checks++;
    if (sticky_flags !== 4'b1000) begin
      fails++;
      $display("FAIL flags_nan_sticky: got %b expected 1000", sticky_flags);
    end
    rsp_ready = 1'b1; step(); rsp_ready = 1'b0;
    accept_one(0, 1'b1, 32'h3F80_0001, 4'd7, ok);
    step();
    flags_clr = 1'b1;
    step();
    flags_clr = 1'b0;
    checks++;
    if ({rsp_valid, rsp_data, rsp_flags, sticky_flags} !== {1'b1, 32'h0000_3F80, 4'b0001, 4'b0001}) begin
      fails++;
      $display("FAIL flags_clr_capture: got valid=%b data=%h flags=%b sticky=%b expected 1 00003f80 0001 0001",
               rsp_valid, rsp_data, rsp_flags, sticky_flags);
    end
    rsp_ready = 1'b1; step(); rsp_ready = 1'b0;
    flags_clr = 1'b1; step(); flags_clr = 1'b0;
    checks++;
    if (sticky_flags !== 4'h0) begin
      fails++;
      $display("FAIL flags_clr_alone: got %b expected 0000", sticky_flags);
    end
  endtask

  task automatic test_random();
    bit busy, hs, rhs, cap, clr_prev, pref;
    int unsigned age, done;
    int g;
    logic [1:0]  pv, pop, exp_rdy;
    logic [31:0] pd [2];
    logic [3:0]  pt [2];
    logic [3:0]  exp_sticky, exp_flags, exp_tag;
    logic [31:0] exp_data;
    logic        exp_op, exp_id;
    busy = 0; hs = 0; rhs = 0; clr_prev = 0; pref = 0; age = 0; done = 0; g = 0;
    pv = '0; pop = '0; exp_sticky = '0; exp_flags = '0; exp_tag = '0; exp_data = '0;
    exp_op = 1'b0; exp_id = 1'b0;
    do_reset();
    for (int c = 0; c < 2000 && done < 40; c++) begin
      cap = 0;
      if (rhs) begin busy = 0; done++; end
      if (hs) begin
        busy = 1; age = 0; pv[g] = 1'b0;
        exp_op = pop[g]; exp_id = g[0]; exp_tag = pt[g];
        if (!exp_op) {exp_flags, exp_data} = ref_b2f(pd[g][15:0]);
        else begin {exp_flags, exp_data[15:0]} = ref_f2b(pd[g]); exp_data[31:16] = 16'h0; end
      end else if (busy) begin
        age++;
        cap = (age == 2);
      end
      if (cap) exp_sticky = (clr_prev ? 4'h0 : exp_sticky) | exp_flags;
      else if (clr_prev) exp_sticky = 4'h0;
      checks++;
      if (rsp_valid !== (busy && age >= 2)) begin
        fails++;
        $display("FAIL rand_rsp_valid: got %b expected %b", rsp_valid, busy && age >= 2);
      end
      checks++;
      if ({cvt_en_b2f, cvt_en_f2b} !== {busy && age == 0 && !exp_op, busy && age == 0 && exp_op}) begin
        fails++;
        $display("FAIL rand_cvt_en: got %b%b expected %b%b", cvt_en_b2f, cvt_en_f2b,
                 busy && age == 0 && !exp_op, busy && age == 0 && exp_op);
      end
      if (busy && age >= 2) begin
        checks++;
        if ({rsp_id, rsp_tag, rsp_data, rsp_flags} !== {exp_id, exp_tag, exp_data, exp_flags}) begin
          fails++;
          $display("FAIL rand_rsp: got %h expected %h", {rsp_id, rsp_tag, rsp_data, rsp_flags},
                   {exp_id, exp_tag, exp_data, exp_flags});
        end
      end
      checks++;
      if (sticky_flags !== exp_sticky) begin
        fails++;
        $display("FAIL rand_sticky: got %b expected %b", sticky_flags, exp_sticky);
      end
      for (int p = 0; p < 2; p++) begin
        if (!pv[p] && $urandom_range(0, 2) == 0) begin
          pv[p] = 1'b1; pop[p] = 1'($urandom_range(0, 1)); pd[p] = $urandom; pt[p] = 4'($urandom);
          if ($urandom_range(0, 3) == 0) pd[p][30:23] = 8'hFF;
          if ($urandom_range(0, 3) == 0) pd[p][14:7] = 8'hFF;
          set_port(p, pop[p], pd[p], pt[p]);
        end
      end
      req_valid = pv;
      rsp_ready = 1'($urandom_range(0, 1));
      flags_clr = ($urandom_range(0, 9) == 0);
      #1;
      exp_rdy = '0;
      if (!busy) begin
        if (pv[pref]) begin g = pref ? 1 : 0; exp_rdy[g] = 1'b1; end
        else if (pv[~pref]) begin g = pref ? 0 : 1; exp_rdy[g] = 1'b1; end
      end
      checks++;
      if (req_ready !== exp_rdy) begin
        fails++;
        $display("FAIL rand_req_ready: got %b expected %b", req_ready, exp_rdy);
      end
      hs = (exp_rdy != 2'b00);
      if (hs) pref = (g == 0);
      rhs = busy && age >= 2 && rsp_ready;
      clr_prev = flags_clr;
      step();
    end
    checks++;
    if (done < 40) begin
      fails++;
      $display("FAIL rand_timeout: got %0d ops expected 40", done);
    end
    idle_inputs();
  endtask

  task automatic test_reset_mid();
    int k;
    idle_inputs();
    set_port(0, 1'b0, 32'h0000_4000, 4'd6);
    req_valid3 = 2'b01;
    #1;
    checks++;
    if (req_ready3 !== 2'b01) begin
      fails++;
      $display("FAIL mid_grant: got %b expected 01", req_ready3);
    end
    step();
    req_valid3 = 2'b00;
    checks++;
    if (cvt_en_b2f3 !== 1'b1) begin
      fails++;
      $display("FAIL mid_exec_en: got %b expected 1", cvt_en_b2f3);
    end
    step();
    reset3 = 1'b1;
    req_valid3 = 2'b11;
    #1;
    checks++;
    if ({req_ready3, rsp_valid3, rsp_id3, rsp_tag3, rsp_data3, rsp_flags3, sticky3, cvt_en_b2f3, cvt_en_f2b3, cvt_operand3} !== 82'h0) begin
      fails++;
      $display("FAIL mid_reset_outputs: got %h expected 0",
               {req_ready3, rsp_valid3, rsp_id3, rsp_tag3, rsp_data3, rsp_flags3, sticky3, cvt_en_b2f3, cvt_en_f2b3, cvt_operand3});
    end
    step(); step();
    reset3 = 1'b0;
    req_valid3 = 2'b00;
    for (int i = 0; i < 8; i++) begin
      checks++;
      if (rsp_valid3 !== 1'b0) begin
        fails++;
        $display("FAIL mid_no_rsp[%0d]: got %b expected 0", i, rsp_valid3);
      end
      step();
    end
    set_port(0, 1'b0, 32'h0000_C0A0, 4'd2);
    set_port(1, 1'b1, 32'h4000_0000, 4'd4);
    req_valid3 = 2'b11;
    #1;
    checks++;
    if (req_ready3 !== 2'b01) begin
      fails++;
      $display("FAIL mid_rr_reset: got %b expected 01", req_ready3);
    end
    step();
    req_valid3 = 2'b00;
    k = 0;
    for (int i = 1; i <= 10 && k == 0; i++) begin
      step();
      if (rsp_valid3) k = i;
    end
    checks++;
    if (k != 4) begin
      fails++;
      $display("FAIL lat3_timing: got rsp after %0d cycles expected 4", k);
    end
    checks++;
    if ({rsp_id3, rsp_tag3, rsp_data3, rsp_flags3} !== {1'b0, 4'd2, 32'hC0A0_0000, 4'h0}) begin
      fails++;
      $display("FAIL lat3_rsp: got %h expected 02c0a000000", {rsp_id3, rsp_tag3, rsp_data3, rsp_flags3});
    end
    rsp_ready = 1'b1; step(); rsp_ready = 1'b0;
  endtask

  initial begin
    test_reset();
    test_basic();
    test_nan();
    test_rr();
    test_backpressure();
    test_flags();
    test_random();
    test_reset_mid();
    $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
    $finish;
  end

endmodule

// File: doc/bf16_cvt_scheduler.md
Name: bf16_cvt_scheduler

Overview:
Shares one BF16→FP32 converter and one FP32→BF16 converter between two requesters (scalar issue port 0, vector-lane port 1).
- Arbitrates between the ports round-robin.
- Pulses the selected converter's instruction enable and waits out the converter latency.
- Returns the result, requester id and tag on a valid/ready response channel.
- Keeps sticky FP exception flags for the CSR file.
Sits between the issue stage and the conversion datapath.

Parameters:
TAG_W, 4, width of the opaque request tag echoed back with the result
CVT_LAT, 1, cycles from the converter's enable edge to a stable result (minimum 1)

Ports:
clk  in  1  clock
reset  in  1  asynchronous, active-high reset
req_valid  in  2  per-port request valid
req_ready  out  2  per-port accept; one-hot or zero
req_op  in  2  per-port op: 0 = BF16→FP32, 1 = FP32→BF16
req_data  in  2x32  per-port operand; BF16 operand in bits [15:0]
req_tag  in  2xTAG_W  per-port tag
cvt_en_b2f  out  1  instruction enable to the BF16→FP32 converter
cvt_en_f2b  out  1  instruction enable to the FP32→BF16 converter
cvt_operand  out  32  operand bus to both converters ([15:0] for b2f)
cvt_res_b2f  in  32  BF16→FP32 result
cvt_flags_b2f  in  4  BF16→FP32 fpcsr {NV,OF,UF,NX}
cvt_res_f2b  in  16  FP32→BF16 result
cvt_flags_f2b  in  4  FP32→BF16 fpcsr
rsp_valid  out  1  response valid
rsp_ready  in  1  response accept
rsp_id  out  1  port that issued the request
rsp_tag  out  TAG_W  echoed tag
rsp_data  out  32  result; f2b results zero-extended {16'h0000, res}
rsp_flags  out  4  flags of this op
flags_clr  in  1  clear sticky flags
sticky_flags  out  4  OR of all op flags since the last clear

Behaviour:
- Clock domain: clk only. reset is asynchronous, active-high.
- Reset values: state IDLE; rr_ptr=0; rsp_valid=0; rsp_id=0; rsp_tag=0; rsp_data=0; rsp_flags=0; sticky_flags=0; cvt_en_*=0; cvt_operand=0. req_ready=0 while reset is high.
- FSM states: IDLE, EXEC, WAIT, RESP. One op in flight at a time.
- IDLE:
  - Grant goes to the valid port with priority; rr_ptr names the preferred port.
  - req_ready[g] is high combinationally for the granted port only.
  - On handshake: latch op, data, tag and id (g); set rr_ptr = ~g; go to EXEC.
  - No valid request: stay in IDLE, rr_ptr unchanged.
- EXEC (exactly 1 cycle):
  - cvt_operand is the latched data.
  - Assert cvt_en_b2f or cvt_en_f2b according to op; never both.
  - Load lat_cnt = CVT_LAT-1; go to WAIT.
- WAIT:
  - Enables are low; cvt_operand is held.
  - While lat_cnt ≠ 0, decrement.
  - At lat_cnt == 0: capture the selected result into rsp_data (zero-extended for f2b) and the matching flags into rsp_flags; set sticky_flags |= flags; go to RESP.
- RESP:
  - rsp_valid=1. rsp_* stay stable until rsp_ready=1.
  - On rsp_ready: rsp_valid←0 next cycle; go to IDLE.
  - req_ready=0 in all states except IDLE.
- Timing: accept at edge N → EXEC cycle N+1 → capture at edge N+1+CVT_LAT. With CVT_LAT=1, rsp_valid is high in cycle N+3. Peak throughput is one op per CVT_LAT+3 cycles.
- flags_clr:
  - flags_clr alone: sticky_flags←0.
  - flags_clr in the same cycle as a WAIT capture: sticky_flags←captured flags (new flags win over the clear).
- Both ports valid: rr_ptr port wins. The loser is guaranteed the next grant if it stays valid (no starvation).
- Requesters must hold req_* stable until accepted.
- reset mid-operation: in-flight op discarded, no response produced, converter enables low immediately, rr_ptr←0.

Decomposition:
- Package cvt_pkg:
  - op encoding constants CVT_B2F=1'b0, CVT_F2B=1'b1
  - state enum {IDLE, EXEC, WAIT, RESP}
  - flag bit indices NV=3, OF=2, UF=1, NX=0
  - typedef cvt_req_t {op, data, tag}
- One sub-module, cvt_rr_arb2: 2-input round-robin grant from req_valid and rr_ptr, plus pointer update on accept.

Test Plan:
- Port0 b2f data=0x0000_3F80, tag=5 → cvt_en_b2f pulses 1 cycle; rsp_valid at N+3; rsp_data=0x3F80_0000, rsp_id=0, rsp_tag=5, rsp_flags=0, sticky=0.
- Port1 b2f data=0x7FC1 (NaN) → rsp_data=0x7FC0_0000, rsp_flags=4'b1000, sticky_flags=4'b1000.
- Both ports valid continuously after reset, 4 ops → grant order 0,1,0,1; req_ready never high on both ports or outside IDLE.
- rsp_ready held low 6 cycles in RESP → rsp_* stable, req_ready=0 on both ports, no cvt_en pulse; op completes on the first rsp_ready cycle.
- Sticky flags=4'b1000, flags_clr asserted in the capture cycle of an f2b op with flags 4'b0001 → sticky_flags=4'b0001; flags_clr alone → 0.
- CVT_LAT=3 build; reset asserted during WAIT → outputs at reset values immediately; no rsp_valid afterwards; next request granted to port 0.
